wrr_pkt_sched: RTL and testbench

WRR_PKT_SCHED -- requirements
Module: wrr_pkt_sched

---
 rtl/wrr_pkg.sv | 15 +
 rtl/wrr_rr_pick.sv | 32 +++
 rtl/wrr_pkt_sched.sv | 99 +++++++++
 tb/tb_wrr_pkt_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin packet scheduler.
// The index-width helper is reused by any arbiter that needs a client index.
package wrr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Width of a client index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrr_rr_pick.sv
// Rotating-priority picker: finds the first set request after ptr_i, wrapping
// around and ending at ptr_i itself. Purely combinational.
module wrr_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;
  int               c;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    c       = 0;
    for (int off = N; off >= 1; off--) begin
      c    = (int'(ptr_i) + off) % N;
      cand = IDX_W'(c);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/wrr_pkt_sched.sv
// Weighted round-robin packet scheduler: grants one client the output channel
// per packet, giving each client up to its weight in packets per turn.
module wrr_pkt_sched
  import wrr_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 4,
  localparam int IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CLIENTS-1:0]              s_valid,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]   s_data,
  input  logic [NUM_CLIENTS-1:0]              s_last,
  output logic [NUM_CLIENTS-1:0]              s_ready,
  input  logic [NUM_CLIENTS*WEIGHT_WIDTH-1:0] i_weight,
  output logic                                m_valid,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic                                m_last,
  output logic [IDX_W-1:0]                    m_src,
  input  logic                                m_ready
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic                    pickFound;
  logic [IDX_W-1:0]        pickIdx;
  logic [WEIGHT_WIDTH-1:0] pickWeight;
  logic                    lastAccept;

  wrr_rr_pick #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (s_valid),
    .ptr_i   (ptr_q),
    .found_o (pickFound),
    .idx_o   (pickIdx)
  );

  assign pickWeight = i_weight[pickIdx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign lastAccept = (state_q == XFER) && s_valid[ptr_q] && m_ready && s_last[ptr_q];
  assign m_src      = ptr_q;

  // ptr starts at the last client so the first search begins at client 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IDX_W'(NUM_CLIENTS - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  // A credited client keeps its turn only while it is still requesting;
  // otherwise its credit is dropped and a fresh search reloads credit.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if ((credit_q != '0) && s_valid[ptr_q]) begin
          state_d = XFER;
        end else if (pickFound) begin
          ptr_d    = pickIdx;
          credit_d = (pickWeight == '0) ? WEIGHT_WIDTH'(1) : pickWeight;
          state_d  = XFER;
        end
      end
      XFER: begin
        if (lastAccept) begin
          state_d = IDLE;
          if (credit_q != '0) credit_d = credit_q - WEIGHT_WIDTH'(1);
        end
      end
    endcase
  end

  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    if (state_q == XFER) begin
      m_valid        = s_valid[ptr_q];
      m_data         = s_data[ptr_q*DATA_WIDTH +: DATA_WIDTH];
      m_last         = s_last[ptr_q];
      s_ready[ptr_q] = m_ready;
    end
  end

endmodule

// File: tb/tb_wrr_pkt_sched.sv
// Directed self-checking bench for wrr_pkt_sched with hand-computed grant orders.
module tb_wrr_pkt_sched;

  logic         clk;
  logic         rst;
  logic [3:0]   s_valid;
  logic [127:0] s_data;
  logic [3:0]   s_last;
  logic [3:0]   s_ready;
  logic [15:0]  i_weight;
  logic         m_valid;
  logic [31:0]  m_data;
  logic         m_last;
  logic [1:0]   m_src;
  logic         m_ready;

  int totalChecks = 0;
  int badChecks   = 0;

  wrr_pkt_sched #(
    .NUM_CLIENTS  (4),
    .DATA_WIDTH   (32),
    .WEIGHT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .i_weight (i_weight),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_src    (m_src),
    .m_ready  (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 1 ns after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalChecks++;
    assert (obs === exp) else begin
      badChecks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input int expSrc);
    #1;
    checkOutput({tag, "_idle_valid"}, 64'(m_valid), 64'd0);
    checkOutput({tag, "_idle_ready"}, 64'(s_ready), 64'd0);
    checkOutput({tag, "_idle_last"},  64'(m_last),  64'd0);
    checkOutput({tag, "_idle_data"},  64'(m_data),  64'd0);
    checkOutput({tag, "_idle_src"},   64'(m_src),   64'(expSrc));
  endtask

  task automatic checkBeat(input string tag, input int expSrc, input logic expValid,
                           input logic [31:0] expData, input logic expLast,
                           input logic [3:0] expReady);
    #1;
    checkOutput({tag, "_src"},   64'(m_src),   64'(expSrc));
    checkOutput({tag, "_valid"}, 64'(m_valid), 64'(expValid));
    checkOutput({tag, "_ready"}, 64'(s_ready), 64'(expReady));
    if (expValid) begin
      checkOutput({tag, "_data"}, 64'(m_data), 64'(expData));
      checkOutput({tag, "_last"}, 64'(m_last), 64'(expLast));
    end
  endtask

  task automatic setBeat(input int c, input logic [31:0] d, input logic l);
    s_data[c*32 +: 32] = d;
    s_last[c]          = l;
  endtask

  task automatic resetDut(input string tag);
    rst      = 1'b1;
    s_valid  = '0;
    s_data   = '0;
    s_last   = '0;
    m_ready  = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] dataOf(input int c, input int beat);
    return 32'hC0DE_0000 | 32'(c << 8) | 32'(beat);
  endfunction

  int order25[14] = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 1, 2, 3, 3, 3};
  int order27[6]  = '{1, 3, 1, 3, 1, 3};
  int order28[6]  = '{0, 1, 0, 0, 0, 1};

  initial begin
    int prev;
    s_valid  = '0;
    s_data   = '0;
    s_last   = '0;
    i_weight = '0;
    m_ready  = 1'b0;

    // Reset state with stray data present on the inputs.
    $display("[TB] reset state");
    resetDut("rst");
    s_data = {4{32'hFFFF_FFFF}};
    s_last = 4'hF;
    checkIdle("rst", 3);

    // Weights {1,2,1,3}, continuous single-beat packets from all clients.
    $display("[TB] weighted order");
    resetDut("w");
    i_weight = {4'd3, 4'd1, 4'd2, 4'd1};
    for (int c = 0; c < 4; c++) setBeat(c, dataOf(c, 0), 1'b1);
    s_valid = 4'hF;
    prev = 3;
    for (int k = 0; k < 14; k++) begin
      checkIdle($sformatf("w%0d", k), prev);
      applyStimulus();
      checkBeat($sformatf("w%0d", k), order25[k], 1'b1, dataOf(order25[k], 0), 1'b1,
                4'(1 << order25[k]));
      prev = order25[k];
      applyStimulus();
    end

    // All weights zero behave as one packet per turn.
    $display("[TB] zero weights");
    resetDut("z");
    i_weight = '0;
    for (int c = 0; c < 4; c++) setBeat(c, dataOf(c, 1), 1'b1);
    s_valid = 4'b1010;
    prev = 3;
    for (int k = 0; k < 6; k++) begin
      checkIdle($sformatf("z%0d", k), prev);
      applyStimulus();
      checkBeat($sformatf("z%0d", k), order27[k], 1'b1, dataOf(order27[k], 1), 1'b1,
                4'(1 << order27[k]));
      prev = order27[k];
      applyStimulus();
    end

    // Client 2 holds the grant across a two-cycle valid gap.
    $display("[TB] packet lock");
    resetDut("lk");
    i_weight = {4{4'd1}};
    s_valid  = 4'b0100;
    setBeat(2, dataOf(2, 1), 1'b0);
    setBeat(0, dataOf(0, 9), 1'b1);
    checkIdle("lk0", 3);
    applyStimulus();
    s_valid = 4'b0101;
    checkBeat("lk_b1", 2, 1'b1, dataOf(2, 1), 1'b0, 4'b0100);
    applyStimulus();
    setBeat(2, dataOf(2, 2), 1'b0);
    checkBeat("lk_b2", 2, 1'b1, dataOf(2, 2), 1'b0, 4'b0100);
    applyStimulus();
    s_valid = 4'b0001;
    checkBeat("lk_gap1", 2, 1'b0, 32'd0, 1'b0, 4'b0100);
    applyStimulus();
    checkBeat("lk_gap2", 2, 1'b0, 32'd0, 1'b0, 4'b0100);
    applyStimulus();
    s_valid = 4'b0101;
    setBeat(2, dataOf(2, 3), 1'b0);
    checkBeat("lk_b3", 2, 1'b1, dataOf(2, 3), 1'b0, 4'b0100);
    applyStimulus();
    setBeat(2, dataOf(2, 4), 1'b1);
    checkBeat("lk_b4", 2, 1'b1, dataOf(2, 4), 1'b1, 4'b0100);
    applyStimulus();
    s_valid = 4'b0001;
    checkIdle("lk1", 2);
    applyStimulus();
    checkBeat("lk_next", 0, 1'b1, dataOf(0, 9), 1'b1, 4'b0001);

    // Downstream stall on a last beat: everything holds, no handshake.
    $display("[TB] backpressure");
    resetDut("bp");
    i_weight = {4{4'd1}};
    s_valid  = 4'b0010;
    setBeat(1, dataOf(1, 1), 1'b0);
    checkIdle("bp0", 3);
    applyStimulus();
    checkBeat("bp_b1", 1, 1'b1, dataOf(1, 1), 1'b0, 4'b0010);
    applyStimulus();
    s_valid = 4'hF;
    for (int c = 0; c < 4; c++) if (c != 1) setBeat(c, dataOf(c, 5), 1'b1);
    setBeat(1, dataOf(1, 2), 1'b1);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkBeat($sformatf("bp_stall%0d", k), 1, 1'b1, dataOf(1, 2), 1'b1, 4'b0000);
      applyStimulus();
    end
    m_ready = 1'b1;
    checkBeat("bp_go", 1, 1'b1, dataOf(1, 2), 1'b1, 4'b0010);
    applyStimulus();
    checkIdle("bp1", 1);
    applyStimulus();
    checkBeat("bp_next", 2, 1'b1, dataOf(2, 5), 1'b1, 4'b0100);

    // Client 0 forfeits credit by dropping valid, then reloads a full turn.
    $display("[TB] credit forfeit");
    resetDut("cf");
    i_weight = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int c = 0; c < 4; c++) setBeat(c, dataOf(c, 7), 1'b1);
    s_valid = 4'b0011;
    prev = 3;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) s_valid = 4'b0010;
      if (k == 2) s_valid = 4'b0011;
      checkIdle($sformatf("cf%0d", k), prev);
      applyStimulus();
      if (k == 2) i_weight = {4'd1, 4'd1, 4'd1, 4'd1};
      checkBeat($sformatf("cf%0d", k), order28[k], 1'b1, dataOf(order28[k], 7), 1'b1,
                4'(1 << order28[k]));
      prev = order28[k];
      applyStimulus();
    end

    // Reset in the middle of a packet abandons it at once.
    $display("[TB] mid-packet reset");
    resetDut("mr");
    i_weight = {4{4'd1}};
    s_valid  = 4'b0100;
    setBeat(2, dataOf(2, 1), 1'b0);
    setBeat(1, dataOf(1, 3), 1'b1);
    checkIdle("mr0", 3);
    applyStimulus();
    checkBeat("mr_b1", 2, 1'b1, dataOf(2, 1), 1'b0, 4'b0100);
    applyStimulus();
    setBeat(2, dataOf(2, 2), 1'b0);
    checkBeat("mr_b2", 2, 1'b1, dataOf(2, 2), 1'b0, 4'b0100);
    rst = 1'b1;
    applyStimulus();
    rst     = 1'b0;
    s_valid = 4'b0110;
    checkIdle("mr1", 3);
    applyStimulus();
    checkBeat("mr_first", 1, 1'b1, dataOf(1, 3), 1'b1, 4'b0010);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
